// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter
//   Shares one single-port memory between the instruction-fetch path (IF) and
//   the load/store path (LS). Each access is sequenced through an FSM; when both
//   paths request at once, the grant alternates (round robin). Loads are
//   extracted and sign/zero extended; sub-word stores use read-modify-write so
//   untouched byte lanes survive.
//
//   Optional feature: define MEM_ARB_MISALIGN_TRAP_EN to trap misaligned half
//   and word accesses (no memory strobe, ls_done with ls_err = 1 and
//   ls_rdata = 0). Without it, misaligned accesses are silently aligned down
//   and ls_err is tied to 0.
//
// Parameters
//   ADDR_W      width of all address ports
//   MEM_RD_LAT  memory read latency in cycles (1..4)
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   if_req/if_addr             fetch request and address (held until if_done)
//   if_rdata/if_done           fetched word, single-cycle completion pulse
//   ls_req/ls_we/ls_size       load/store request, 1 = store, 00 b / 01 h / 1x w
//   ls_unsigned                zero-extend loaded data
//   ls_addr/ls_wdata           byte address, right-aligned store data
//   ls_rdata/ls_done/ls_err    extended load result, completion pulse, error
//   mem_addr/mem_wdata         word-aligned memory address, write data
//   mem_rd_en/mem_wr_en        memory read / write strobes
//   mem_rdata                  memory read data (MEM_RD_LAT cycles after rd_en)
//   busy                       high whenever the FSM is not idle

module mem_access_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned MEM_RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  // instruction fetch
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_done,
  // load/store
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [1:0]        ls_size,
  input  logic              ls_unsigned,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [31:0]       ls_wdata,
  output logic [31:0]       ls_rdata,
  output logic              ls_done,
  output logic              ls_err,
  // memory
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  input  logic [31:0]       mem_rdata,
  // status
  output logic              busy
);

  localparam logic [3:0] IDLE    = 4'd0;
  localparam logic [3:0] IF_RD   = 4'd1;
  localparam logic [3:0] IF_WAIT = 4'd2;
  localparam logic [3:0] IF_RSP  = 4'd3;
  localparam logic [3:0] LS_RD   = 4'd4;
  localparam logic [3:0] LS_WAIT = 4'd5;
  localparam logic [3:0] LS_RSP  = 4'd6;
  localparam logic [3:0] LS_WR   = 4'd7;
  localparam logic [3:0] LS_ERR  = 4'd8;

  localparam logic GRANT_IF = 1'b0;
  localparam logic GRANT_LS = 1'b1;

  // Wait counter load value: the WAIT state lasts MEM_RD_LAT-1 cycles and
  // leaves when the counter reads zero.
  localparam int unsigned WAIT_INIT = (MEM_RD_LAT > 1) ? (MEM_RD_LAT - 2) : 0;

  logic [3:0]  state_q, state_d;
  logic [1:0]  wait_q, wait_d;
  logic        last_grant_q, last_grant_d;

  // LS operation attributes captured at grant time
  logic        we_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [1:0]  off_q;

  logic [31:0] merge_q;
  logic [31:0] if_rdata_q;
  logic [31:0] ls_rdata_q;
  logic        if_done_q;
  logic        ls_done_q;

  logic        if_act, ls_act;
  logic        grant_if, grant_ls;
  logic        trap;
  logic        ls_word_store;

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_ext;
  logic [31:0] store_merge;

  logic [ADDR_W-1:0] if_addr_al;
  logic [ADDR_W-1:0] ls_addr_al;

  logic        unused_if_addr_lo;
  assign unused_if_addr_lo = ^if_addr[1:0];

  assign if_addr_al = {if_addr[ADDR_W-1:2], 2'b00};
  assign ls_addr_al = {ls_addr[ADDR_W-1:2], 2'b00};

`ifdef MEM_ARB_MISALIGN_TRAP_EN
  assign trap = ((ls_size == 2'b01) && ls_addr[0]) ||
                (ls_size[1] && (ls_addr[1:0] != 2'b00));
`else
  assign trap = 1'b0;
`endif

  assign ls_word_store = ls_we && ls_size[1];

  // ---------------------------------------------------------------------------
  // Arbitration and next state
  // ---------------------------------------------------------------------------
  always_comb begin
    // A requester whose done pulse is high is still holding req; ignore it.
    if_act   = if_req && !if_done_q;
    ls_act   = ls_req && !ls_done_q;
    grant_if = if_act && (!ls_act || (last_grant_q == GRANT_LS));
    grant_ls = ls_act && !grant_if;
  end

  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (grant_if) begin
          state_d      = IF_RD;
          last_grant_d = GRANT_IF;
        end else if (grant_ls) begin
          last_grant_d = GRANT_LS;
          if (trap) begin
            state_d = LS_ERR;
          end else if (ls_word_store) begin
            state_d = LS_WR;
          end else begin
            state_d = LS_RD;
          end
        end
      end
      IF_RD: begin
        if (MEM_RD_LAT <= 1) begin
          state_d = IF_RSP;
        end else begin
          state_d = IF_WAIT;
          wait_d  = 2'(WAIT_INIT);
        end
      end
      IF_WAIT: begin
        if (wait_q == 2'd0) begin
          state_d = IF_RSP;
        end else begin
          wait_d = wait_q - 2'd1;
        end
      end
      IF_RSP: state_d = IDLE;
      LS_RD: begin
        if (MEM_RD_LAT <= 1) begin
          state_d = LS_RSP;
        end else begin
          state_d = LS_WAIT;
          wait_d  = 2'(WAIT_INIT);
        end
      end
      LS_WAIT: begin
        if (wait_q == 2'd0) begin
          state_d = LS_RSP;
        end else begin
          wait_d = wait_q - 2'd1;
        end
      end
      // Sub-word stores come back through RSP to write the merged word.
      LS_RSP:  state_d = we_q ? LS_WR : IDLE;
      LS_WR:   state_d = IDLE;
      LS_ERR:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Load extraction and store merge
  // ---------------------------------------------------------------------------
  always_comb begin
    case (off_q)
      2'd0:    rd_byte = mem_rdata[7:0];
      2'd1:    rd_byte = mem_rdata[15:8];
      2'd2:    rd_byte = mem_rdata[23:16];
      default: rd_byte = mem_rdata[31:24];
    endcase
    rd_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    case (size_q)
      2'b00:   load_ext = {{24{!uns_q && rd_byte[7]}}, rd_byte};
      2'b01:   load_ext = {{16{!uns_q && rd_half[15]}}, rd_half};
      default: load_ext = mem_rdata;
    endcase

    store_merge = mem_rdata;
    case (size_q)
      2'b00: begin
        case (off_q)
          2'd0:    store_merge[7:0]   = ls_wdata[7:0];
          2'd1:    store_merge[15:8]  = ls_wdata[7:0];
          2'd2:    store_merge[23:16] = ls_wdata[7:0];
          default: store_merge[31:24] = ls_wdata[7:0];
        endcase
      end
      2'b01: begin
        if (off_q[1]) begin
          store_merge[31:16] = ls_wdata[15:0];
        end else begin
          store_merge[15:0] = ls_wdata[15:0];
        end
      end
      default: store_merge = ls_wdata;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      wait_q       <= 2'd0;
      last_grant_q <= GRANT_LS;
      we_q         <= 1'b0;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      off_q        <= 2'b00;
      merge_q      <= 32'd0;
      if_rdata_q   <= 32'd0;
      ls_rdata_q   <= 32'd0;
      if_done_q    <= 1'b0;
      ls_done_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      last_grant_q <= last_grant_d;

      if ((state_q == IDLE) && grant_ls) begin
        we_q   <= ls_we;
        size_q <= ls_size;
        uns_q  <= ls_unsigned;
        off_q  <= ls_addr[1:0];
      end

      if (state_q == IF_RSP) begin
        if_rdata_q <= mem_rdata;
      end

      if (state_q == LS_RSP) begin
        if (we_q) begin
          merge_q <= store_merge;
        end else begin
          ls_rdata_q <= load_ext;
        end
      end

      if (state_q == LS_ERR) begin
        ls_rdata_q <= 32'd0;
      end

      if_done_q <= (state_q == IF_RSP);
      ls_done_q <= ((state_q == LS_RSP) && !we_q) || (state_q == LS_WR) ||
                   (state_q == LS_ERR);
    end
  end

`ifdef MEM_ARB_MISALIGN_TRAP_EN
  logic ls_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ls_err_q <= 1'b0;
    end else begin
      ls_err_q <= (state_q == LS_ERR);
    end
  end

  assign ls_err = ls_err_q;
`else
  assign ls_err = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Outputs, decoded from the registered state
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_rd_en = (state_q == IF_RD) || (state_q == LS_RD);
    mem_wr_en = (state_q == LS_WR);
    mem_addr  = '0;
    mem_wdata = 32'd0;
    case (state_q)
      IF_RD: mem_addr = if_addr_al;
      LS_RD: mem_addr = ls_addr_al;
      LS_WR: begin
        mem_addr  = ls_addr_al;
        mem_wdata = size_q[1] ? ls_wdata : merge_q;
      end
      default: ;
    endcase
  end

  assign if_rdata = if_rdata_q;
  assign if_done  = if_done_q;
  assign ls_rdata = ls_rdata_q;
  assign ls_done  = ls_done_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_mem_access_arbiter.sv
`timescale 1ns/1ps
module tb_mem_access_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- DUT with MEM_RD_LAT = 1 ----------------
  logic        rst, if_req, if_done, ls_req, ls_we, ls_unsigned, ls_done, ls_err;
  logic [31:0] if_addr, if_rdata, ls_addr, ls_wdata, ls_rdata;
  logic [1:0]  ls_size;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_rd_en, mem_wr_en, busy;

  mem_access_arbiter #(.ADDR_W(32), .MEM_RD_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_unsigned(ls_unsigned),
    .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_rdata(ls_rdata), .ls_done(ls_done),
    .ls_err(ls_err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_rdata(mem_rdata), .busy(busy)
  );

  logic [31:0] mem1 [0:255];
  always @(posedge clk) begin
    if (rst) begin
      mem1[8'h40] <= 32'h80FF7F01;
      mem1[8'h80] <= 32'h0BADF00D;
    end else begin
      if (mem_wr_en) mem1[mem_addr[9:2]] <= mem_wdata;
      if (mem_rd_en) mem_rdata <= mem1[mem_addr[9:2]];
    end
  end

  // ---------------- DUT with MEM_RD_LAT = 3 ----------------
  logic        rst3, if_req3, if_done3, ls_req3, ls_we3, ls_unsigned3, ls_done3, ls_err3;
  logic [31:0] if_addr3, if_rdata3, ls_addr3, ls_wdata3, ls_rdata3;
  logic [1:0]  ls_size3;
  logic [31:0] mem_addr3, mem_wdata3, mem_rdata3;
  logic        mem_rd_en3, mem_wr_en3, busy3;

  mem_access_arbiter #(.ADDR_W(32), .MEM_RD_LAT(3)) dut3 (
    .clk(clk), .rst(rst3),
    .if_req(if_req3), .if_addr(if_addr3), .if_rdata(if_rdata3), .if_done(if_done3),
    .ls_req(ls_req3), .ls_we(ls_we3), .ls_size(ls_size3), .ls_unsigned(ls_unsigned3),
    .ls_addr(ls_addr3), .ls_wdata(ls_wdata3), .ls_rdata(ls_rdata3), .ls_done(ls_done3),
    .ls_err(ls_err3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
    .mem_rd_en(mem_rd_en3), .mem_wr_en(mem_wr_en3), .mem_rdata(mem_rdata3), .busy(busy3)
  );

  logic [31:0] mem3 [0:255];
  logic [31:0] p3_0, p3_1, p3_2;
  always @(posedge clk) begin
    if (rst3) mem3[8'h40] <= 32'h13572468;
    else if (mem_wr_en3) mem3[mem_addr3[9:2]] <= mem_wdata3;
    p3_0 <= mem3[mem_addr3[9:2]];
    p3_1 <= p3_0;
    p3_2 <= p3_1;
  end
  assign mem_rdata3 = p3_2;

  // ---------------- bench bookkeeping ----------------
  int          rd_cnt = 0, wr_cnt = 0, wr_cnt3 = 0;
  logic [31:0] last_rd_addr, last_wr_addr, last_wr_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Advance one cycle, sample #1 after the edge, record strobes and check invariants.
  task automatic step();
    @(posedge clk);
    #1;
    if (mem_rd_en) begin rd_cnt++; last_rd_addr = mem_addr; end
    if (mem_wr_en) begin wr_cnt++; last_wr_addr = mem_addr; last_wr_data = mem_wdata; end
    if (mem_wr_en3) wr_cnt3++;
    if (!rst) begin
      checks++;
      if ((mem_rd_en && mem_wr_en) || (if_done && ls_done) || (ls_err && !ls_done) ||
          (mem_addr[1:0] != 2'b00)) begin
        errors++;
        $display("FAIL invariant: rd=%b wr=%b if_done=%b ls_done=%b ls_err=%b addr=0x%08h",
                 mem_rd_en, mem_wr_en, if_done, ls_done, ls_err, mem_addr);
      end
    end
  endtask

  task automatic run_ls(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output int lat, output logic [31:0] rdata, output logic err);
    ls_we = we; ls_size = size; ls_unsigned = uns; ls_addr = addr; ls_wdata = wdata;
    ls_req = 1'b1;
    lat = -1; rdata = 32'hxxxxxxxx; err = 1'bx;
    for (int n = 1; n <= 20; n++) begin
      step();
      if (ls_done) begin
        lat = n; rdata = ls_rdata; err = ls_err;
        ls_req = 1'b0;
        break;
      end
    end
    ls_req = 1'b0;
    step();
  endtask

  // Raise if_req and ls_req together (IF fetches 0x100, LS loads word 0x200).
  task automatic run_tie(input string name, input int exp_if_n, input int exp_ls_n);
    int if_n, ls_n;
    logic [31:0] if_d, ls_d;
    if_addr = 32'h100;
    ls_we = 1'b0; ls_size = 2'b10; ls_unsigned = 1'b0; ls_addr = 32'h200;
    if_req = 1'b1; ls_req = 1'b1;
    if_n = -1; ls_n = -1; if_d = '0; ls_d = '0;
    for (int n = 1; n <= 20; n++) begin
      step();
      if (if_done && if_n < 0) begin if_n = n; if_d = if_rdata; if_req = 1'b0; end
      if (ls_done && ls_n < 0) begin ls_n = n; ls_d = ls_rdata; ls_req = 1'b0; end
      if (if_n >= 0 && ls_n >= 0) break;
    end
    if_req = 1'b0; ls_req = 1'b0;
    check({name, " if_done cycle"}, 32'(if_n), 32'(exp_if_n));
    check({name, " ls_done cycle"}, 32'(ls_n), 32'(exp_ls_n));
    check({name, " if_rdata"}, if_d, 32'h80FF7F01);
    check({name, " ls_rdata"}, ls_d, 32'h0BADF00D);
    step();
  endtask

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk_rd;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_rd;
    int          exp_wr;
    logic [31:0] exp_wdata;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  function automatic vec_t mk(input string name, input logic we, input logic [1:0] size,
                              input logic uns, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic chk_rd,
                              input logic [31:0] exp_rdata, input logic exp_err,
                              input int exp_lat, input int exp_rd, input int exp_wr,
                              input logic [31:0] exp_wdata);
    vec_t v;
    v.name = name; v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.chk_rd = chk_rd; v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat;
    v.exp_rd = exp_rd; v.exp_wr = exp_wr; v.exp_wdata = exp_wdata;
    return v;
  endfunction

  initial begin
    int          lat, rd0, wr0, dn;
    logic [31:0] rdata;
    logic        err;

    vecs[0]  = mk("lb 0x103",  0, 2'b00, 0, 32'h103, 0, 1, 32'hFFFFFF80, 0, 3, 1, 0, 0);
    vecs[1]  = mk("lbu 0x103", 0, 2'b00, 1, 32'h103, 0, 1, 32'h00000080, 0, 3, 1, 0, 0);
    vecs[2]  = mk("lh 0x102",  0, 2'b01, 0, 32'h102, 0, 1, 32'hFFFF80FF, 0, 3, 1, 0, 0);
    vecs[3]  = mk("lhu 0x100", 0, 2'b01, 1, 32'h100, 0, 1, 32'h00007F01, 0, 3, 1, 0, 0);
    vecs[4]  = mk("lb 0x101",  0, 2'b00, 0, 32'h101, 0, 1, 32'h0000007F, 0, 3, 1, 0, 0);
    vecs[5]  = mk("lw 0x100",  0, 2'b10, 0, 32'h100, 0, 1, 32'h80FF7F01, 0, 3, 1, 0, 0);
    vecs[6]  = mk("sb 0x101",  1, 2'b00, 0, 32'h101, 32'h000000AB, 0, 0, 0, 4, 1, 1,
                  32'h80FFAB01);
    vecs[7]  = mk("lw 0x100 after sb", 0, 2'b11, 0, 32'h100, 0, 1, 32'h80FFAB01, 0, 3, 1, 0, 0);
    vecs[8]  = mk("sw 0x200",  1, 2'b10, 0, 32'h200, 32'hDEADBEEF, 0, 0, 0, 2, 0, 1,
                  32'hDEADBEEF);
    vecs[9]  = mk("sh 0x202",  1, 2'b01, 0, 32'h202, 32'hCAFE1234, 0, 0, 0, 4, 1, 1,
                  32'h1234BEEF);
    vecs[10] = mk("lhu 0x202", 0, 2'b01, 1, 32'h202, 0, 1, 32'h00001234, 0, 3, 1, 0, 0);
    vecs[11] = mk("lh 0x200",  0, 2'b01, 0, 32'h200, 0, 1, 32'hFFFFBEEF, 0, 3, 1, 0, 0);
`ifdef MEM_ARB_MISALIGN_TRAP_EN
    vecs[12] = mk("lw 0x102",  0, 2'b10, 0, 32'h102, 0, 1, 32'h00000000, 1, 2, 0, 0, 0);
`else
    vecs[12] = mk("lw 0x102",  0, 2'b10, 0, 32'h102, 0, 1, 32'h80FFAB01, 0, 3, 1, 0, 0);
`endif

    rst = 1'b1; rst3 = 1'b1;
    if_req = 0; if_addr = 0; ls_req = 0; ls_we = 0; ls_size = 0; ls_unsigned = 0;
    ls_addr = 0; ls_wdata = 0;
    if_req3 = 0; if_addr3 = 0; ls_req3 = 0; ls_we3 = 0; ls_size3 = 0; ls_unsigned3 = 0;
    ls_addr3 = 0; ls_wdata3 = 0;
    repeat (3) step();
    rst = 1'b0; rst3 = 1'b0;

    // Reset state
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset strobes/dones", {27'd0, mem_rd_en, mem_wr_en, if_done, ls_done, ls_err}, 32'd0);
    check("reset mem_addr", mem_addr, 32'd0);
    check("reset rdata", if_rdata | ls_rdata, 32'd0);

    // Arbitration: IF wins first tie after reset, then alternates
    run_tie("tie1", 3, 6);
    run_tie("tie2", 3, 6);
    if_addr = 32'h100; if_req = 1'b1; dn = -1;
    for (int n = 1; n <= 20; n++) begin
      step();
      if (if_done) begin dn = n; if_req = 1'b0; break; end
    end
    if_req = 1'b0;
    check("if alone done cycle", 32'(dn), 32'd3);
    step();
    run_tie("tie3", 6, 3);

    // Table-driven load/store vectors
    for (int i = 0; i < NV; i++) begin
      rd0 = rd_cnt; wr0 = wr_cnt;
      run_ls(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
             lat, rdata, err);
      check({vecs[i].name, " latency"}, 32'(lat), 32'(vecs[i].exp_lat));
      check({vecs[i].name, " ls_err"}, {31'd0, err}, {31'd0, vecs[i].exp_err});
      check({vecs[i].name, " rd strobes"}, 32'(rd_cnt - rd0), 32'(vecs[i].exp_rd));
      check({vecs[i].name, " wr strobes"}, 32'(wr_cnt - wr0), 32'(vecs[i].exp_wr));
      if (vecs[i].chk_rd) check({vecs[i].name, " ls_rdata"}, rdata, vecs[i].exp_rdata);
      if (vecs[i].exp_rd > 0)
        check({vecs[i].name, " rd addr"}, last_rd_addr, {vecs[i].addr[31:2], 2'b00});
      if (vecs[i].exp_wr > 0) begin
        check({vecs[i].name, " wr addr"}, last_wr_addr, {vecs[i].addr[31:2], 2'b00});
        check({vecs[i].name, " wr data"}, last_wr_data, vecs[i].exp_wdata);
      end
    end

    // Reset during LS_WAIT on the MEM_RD_LAT = 3 instance
    ls_we3 = 1'b0; ls_size3 = 2'b10; ls_addr3 = 32'h100; ls_req3 = 1'b1;
    step();
    check("lat3 rd strobe in LS_RD", {31'd0, mem_rd_en3}, 32'd1);
    step();
    check("lat3 waiting busy/no strobe", {30'd0, busy3, mem_rd_en3}, 32'd2);
    rst3 = 1'b1; ls_req3 = 1'b0;
    step();
    rst3 = 1'b0;
    check("lat3 after reset busy", {31'd0, busy3}, 32'd0);
    check("lat3 after reset outputs",
          {28'd0, mem_rd_en3, mem_wr_en3, ls_done3, if_done3} | mem_addr3 | ls_rdata3, 32'd0);
    dn = 0;
    for (int n = 0; n < 5; n++) begin
      step();
      if (ls_done3) dn++;
    end
    check("lat3 abandoned: no done", 32'(dn), 32'd0);
    check("lat3 abandoned: no write", 32'(wr_cnt3), 32'd0);
    ls_req3 = 1'b1; dn = -1; rdata = '0;
    for (int n = 1; n <= 20; n++) begin
      step();
      if (ls_done3) begin dn = n; rdata = ls_rdata3; ls_req3 = 1'b0; break; end
    end
    ls_req3 = 1'b0;
    check("lat3 reissue latency", 32'(dn), 32'd5);
    check("lat3 reissue ls_rdata", rdata, 32'h13572468);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
